dcache_lsu: RTL and testbench

CPU-side load/store issue unit: the requester that drives the non-blocking `dcache` CPU port. It takes one memory op at a time from the execute stage and holds `send_pulse` until the dcache accepts. It tracks destination registers of outstanding load misses in a scoreboard and merges load-hit and miss-return data onto a single register-file writeback port. It sits between the execute/memory pipeline stage and `dcache`.

---
 rtl/dcache_lsu_pkg.sv | 25 ++
 rtl/dcache_lsu_if.sv | 25 ++
 rtl/dcache_lsu_reg_scoreboard.sv | 49 ++++
 rtl/dcache_lsu.sv | 130 +++++++++++++
 tb/tb_dcache_lsu.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_lsu_pkg.sv
// lsu_pkg: shared types for the load/store issue unit.
//   lsu_state_t : issue FSM states
//   mem_req_t   : latched memory op (lw, rd, addr, data)
//   wb_t        : register-file writeback beat
//   sat_inc     : saturating 32-bit increment for statistics
package lsu_pkg;
    typedef enum logic [1:0] {IDLE, SEND, RESP} lsu_state_t;

    typedef struct packed {
        logic        lw;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_req_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/dcache_lsu_if.sv
// dcache_lsu_if: CPU-side dcache port.
//   master : LSU side (drives the request, receives responses/returns)
//   slave  : dcache side
interface dcache_lsu_if;
    logic [4:0]  regD_in;
    logic [31:0] addr_in;
    logic [31:0] store_data;
    logic        lw;
    logic        send_pulse;
    logic        hit_ack;
    logic        miss_send;
    logic [4:0]  regD_out;
    logic [31:0] load_data;
    logic        load_done_stall;
    logic        passive_stall;

    modport master (
        output regD_in, addr_in, store_data, lw, send_pulse,
        input  hit_ack, miss_send, regD_out, load_data, load_done_stall, passive_stall
    );
    modport slave (
        input  regD_in, addr_in, store_data, lw, send_pulse,
        output hit_ack, miss_send, regD_out, load_data, load_done_stall, passive_stall
    );
endinterface

// File: rtl/dcache_lsu_reg_scoreboard.sv
// reg_scoreboard: pending-destination vector for outstanding load misses.
//   set_en/set_rd : a load miss was issued (bit set only for rd != 0)
//   clr_en/clr_rd : a miss return is being written back
//   q1/q2 -> q_busy : source-register hazard query
//   sb, out_cnt     : raw vector and number of outstanding misses
module reg_scoreboard #(
    parameter int MSHR_DEPTH = 4,
    localparam int CNT_W = $clog2(MSHR_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [4:0]       set_rd,
    input  logic             clr_en,
    input  logic [4:0]       clr_rd,
    input  logic [4:0]       q1,
    input  logic [4:0]       q2,
    output logic             q_busy,
    output logic [31:0]      sb,
    output logic [CNT_W-1:0] out_cnt
);
    logic [31:0] sb_nxt;

    // Clear first, then set: distinct bits both take effect.
    always_comb begin
        sb_nxt = sb;
        if (clr_en)
            sb_nxt[clr_rd] = 1'b0;
        if (set_en && set_rd != 5'd0)
            sb_nxt[set_rd] = 1'b1;
    end

    // A miss to rd 0 still occupies an MSHR, so the count tracks every miss.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb      <= '0;
            out_cnt <= '0;
        end else begin
            sb <= sb_nxt;
            case ({set_en, clr_en})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    assign q_busy = sb[q1] | sb[q2];
endmodule

// File: rtl/dcache_lsu.sv
// dcache_lsu: single-op load/store issue unit in front of a non-blocking dcache.
//   req_*          : op from execute; req_ready handshakes acceptance
//   dc (master)    : dcache CPU port; request outputs are held from the latched op
//   src1/src2      : hazard query, src_busy high if either has a miss pending
//   wb_*           : merged register-file write (miss return > skid > load hit)
//   hit_cnt/miss_cnt : saturating statistics
module dcache_lsu
    import lsu_pkg::*;
#(
    parameter int MSHR_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_lw,
    input  logic [4:0]   req_rd,
    input  logic [31:0]  req_addr,
    input  logic [31:0]  req_data,
    dcache_lsu_if.master dc,
    input  logic [4:0]   src1,
    input  logic [4:0]   src2,
    output logic         src_busy,
    output logic         wb_valid,
    output logic [4:0]   wb_rd,
    output logic [31:0]  wb_data,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
);
    localparam int CNT_W = $clog2(MSHR_DEPTH + 1);

    lsu_state_t       state;
    mem_req_t         op_q;
    wb_t              skid;
    wb_t              wb;
    logic             send_q;
    logic [31:0]      sb;
    logic [CNT_W-1:0] out_cnt;
    logic             blk, hit, miss, ld_hit, collide;

    // Responses only count while waiting for one; hit_ack beats miss_send.
    assign hit     = (state == RESP) && !skid.valid && dc.hit_ack;
    assign miss    = (state == RESP) && !skid.valid && dc.miss_send && !dc.hit_ack;
    assign ld_hit  = hit && op_q.lw;
    assign collide = ld_hit && dc.load_done_stall;

    assign blk       = req_lw && (sb[req_rd] || out_cnt == CNT_W'(MSHR_DEPTH));
    assign req_ready = (state == IDLE) && !blk;

    assign dc.regD_in    = op_q.rd;
    assign dc.addr_in    = op_q.addr;
    assign dc.store_data = op_q.data;
    assign dc.lw         = op_q.lw;
    assign dc.send_pulse = send_q;

    reg_scoreboard #(.MSHR_DEPTH(MSHR_DEPTH)) u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (miss && op_q.lw),
        .set_rd  (op_q.rd),
        .clr_en  (dc.load_done_stall),
        .clr_rd  (dc.regD_out),
        .q1      (src1),
        .q2      (src2),
        .q_busy  (src_busy),
        .sb      (sb),
        .out_cnt (out_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            op_q   <= '0;
            send_q <= 1'b0;
            skid   <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid && req_ready) begin
                    op_q   <= '{lw: req_lw, rd: req_rd, addr: req_addr, data: req_data};
                    send_q <= 1'b1;
                    state  <= SEND;
                end
                SEND: if (!dc.load_done_stall && !dc.passive_stall) begin
                    send_q <= 1'b0;
                    state  <= RESP;
                end
                RESP: begin
                    if (skid.valid) begin
                        // Drain only when no miss return competes for the port.
                        if (!dc.load_done_stall) begin
                            skid.valid <= 1'b0;
                            state      <= IDLE;
                        end
                    end else if (collide) begin
                        // regD_out carries the miss return this cycle, so the
                        // hit's destination comes from the latched op.
                        skid <= '{valid: 1'b1, rd: op_q.rd, data: dc.load_data};
                    end else if (hit || miss) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        wb = '0;
        if (dc.load_done_stall)
            wb = '{valid: 1'b1, rd: dc.regD_out, data: dc.load_data};
        else if (skid.valid)
            wb = skid;
        else if (ld_hit)
            wb = '{valid: 1'b1, rd: dc.regD_out, data: dc.load_data};
    end

    assign wb_valid = wb.valid && (wb.rd != 5'd0);
    assign wb_rd    = wb.rd;
    assign wb_data  = wb.data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit)  hit_cnt  <= sat_inc(hit_cnt);
            if (miss) miss_cnt <= sat_inc(miss_cnt);
        end
    end
endmodule

// File: tb/tb_dcache_lsu.sv
// tb_dcache_lsu: directed test of dcache_lsu; the bench plays the dcache.
module tb_dcache_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid, req_ready, req_lw;
    logic [4:0]  req_rd, src1, src2, wb_rd;
    logic [31:0] req_addr, req_data, wb_data, hit_cnt, miss_cnt;
    logic        src_busy, wb_valid;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    dcache_lsu_if dc();

    dcache_lsu #(.MSHR_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_lw    (req_lw),
        .req_rd    (req_rd),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .dc        (dc),
        .src1      (src1),
        .src2      (src2),
        .src_busy  (src_busy),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept an op, check the SEND beat, and return positioned in RESP.
    task automatic issue(input logic lw_i, input logic [4:0] rd_i, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_lw = lw_i; req_rd = rd_i; req_addr = a; req_data = d;
        #1;
        chk("issue_ready", 32'(req_ready), 32'd1);
        tick;
        req_valid = 1'b0; req_lw = 1'b0;
        #1;
        chk("issue_send", 32'(dc.send_pulse), 32'd1);
        chk("issue_addr", dc.addr_in, a);
        chk("issue_lw", 32'(dc.lw), 32'(lw_i));
        chk("issue_rd", 32'(dc.regD_in), 32'(rd_i));
        tick;
    endtask

    initial begin
        req_valid = 1'b0; req_lw = 1'b0; req_rd = '0; req_addr = '0; req_data = '0;
        src1 = '0; src2 = '0;
        dc.hit_ack = 1'b0; dc.miss_send = 1'b0; dc.regD_out = '0; dc.load_data = '0;
        dc.load_done_stall = 1'b0; dc.passive_stall = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_send", 32'(dc.send_pulse), 32'd0);
        chk("rst_addr", dc.addr_in, 32'd0);
        chk("rst_wb", 32'(wb_valid), 32'd0);
        chk("rst_hitcnt", hit_cnt, 32'd0);
        chk("rst_busy", 32'(src_busy), 32'd0);
        rst = 1'b1;
        tick;

        // store to 0x100, hit, no writeback
        issue(1'b0, 5'd0, 32'h100, 32'h100);
        chk("st_data_held", dc.store_data, 32'h100);
        chk("st_send_drop", 32'(dc.send_pulse), 32'd0);
        dc.hit_ack = 1'b1;
        #1;
        chk("st_no_wb", 32'(wb_valid), 32'd0);
        tick;
        dc.hit_ack = 1'b0;
        #1;
        chk("st_idle_t3", 32'(req_ready), 32'd1);

        // load rd 5 hit: combinational writeback
        issue(1'b1, 5'd5, 32'h200, 32'h0);
        dc.hit_ack = 1'b1; dc.regD_out = 5'd5; dc.load_data = 32'h200;
        #1;
        chk("ldhit_wbv", 32'(wb_valid), 32'd1);
        chk("ldhit_rd", 32'(wb_rd), 32'd5);
        chk("ldhit_data", wb_data, 32'h200);
        tick;
        dc.hit_ack = 1'b0;
        #1;
        // the earlier store hit also counts
        chk("ldhit_cnt", hit_cnt, 32'd2);
        chk("ldhit_wb_off", 32'(wb_valid), 32'd0);

        // load rd 12 miss, WAW block, return
        issue(1'b1, 5'd12, 32'h300, 32'h0);
        dc.miss_send = 1'b1; dc.regD_out = 5'd12;
        #1;
        chk("miss_no_wb", 32'(wb_valid), 32'd0);
        tick;
        dc.miss_send = 1'b0; src1 = 5'd12;
        #1;
        chk("miss_busy", 32'(src_busy), 32'd1);
        chk("miss_cnt1", miss_cnt, 32'd1);
        req_valid = 1'b1; req_lw = 1'b1; req_rd = 5'd12;
        #1;
        chk("waw_block", 32'(req_ready), 32'd0);
        tick;
        chk("waw_not_sent", 32'(dc.send_pulse), 32'd0);
        dc.load_done_stall = 1'b1; dc.regD_out = 5'd12; dc.load_data = 32'hCAFE;
        #1;
        chk("ret_wbv", 32'(wb_valid), 32'd1);
        chk("ret_rd", 32'(wb_rd), 32'd12);
        chk("ret_data", wb_data, 32'hCAFE);
        chk("ret_busy_same", 32'(src_busy), 32'd1);
        tick;
        dc.load_done_stall = 1'b0;
        #1;
        chk("ret_free_next", 32'(src_busy), 32'd0);
        chk("ret_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b0; req_lw = 1'b0; src1 = '0;

        // passive_stall for 3 cycles during SEND
        req_valid = 1'b1; req_lw = 1'b0; req_rd = '0; req_addr = 32'h400; req_data = 32'hDEADBEEF;
        tick;
        req_valid = 1'b0; dc.passive_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_send", 32'(dc.send_pulse), 32'd1);
            chk("stall_addr", dc.addr_in, 32'h400);
            chk("stall_data", dc.store_data, 32'hDEADBEEF);
            tick;
        end
        dc.passive_stall = 1'b0;
        #1;
        chk("stall_send4", 32'(dc.send_pulse), 32'd1);
        tick;
        chk("stall_accepted", 32'(dc.send_pulse), 32'd0);
        dc.hit_ack = 1'b1;
        tick;
        dc.hit_ack = 1'b0;

        // four outstanding misses fill the MSHRs
        for (int i = 1; i <= 4; i++) begin
            issue(1'b1, 5'(i), 32'h1000 + 32'(i), 32'h0);
            dc.miss_send = 1'b1; dc.regD_out = 5'(i);
            tick;
            dc.miss_send = 1'b0;
        end
        #1;
        chk("mshr_misscnt", miss_cnt, 32'd5);
        req_valid = 1'b1; req_lw = 1'b1; req_rd = 5'd9;
        #1;
        chk("mshr_full_block", 32'(req_ready), 32'd0);
        req_lw = 1'b0; req_addr = 32'h500;
        #1;
        chk("mshr_store_ok", 32'(req_ready), 32'd1);
        tick;
        req_valid = 1'b0;
        tick;
        dc.hit_ack = 1'b1;
        tick;
        dc.hit_ack = 1'b0;
        req_valid = 1'b1; req_lw = 1'b1; req_rd = 5'd9;
        #1;
        chk("mshr_still_full", 32'(req_ready), 32'd0);
        dc.load_done_stall = 1'b1; dc.regD_out = 5'd2; dc.load_data = 32'h22;
        #1;
        chk("mshr_ret_rd", 32'(wb_rd), 32'd2);
        tick;
        dc.load_done_stall = 1'b0;
        #1;
        chk("mshr_freed", 32'(req_ready), 32'd1);
        req_valid = 1'b0; req_lw = 1'b0;

        // load hit to rd 0 is suppressed
        issue(1'b1, 5'd0, 32'h600, 32'h0);
        dc.hit_ack = 1'b1; dc.regD_out = 5'd0; dc.load_data = 32'h66;
        #1;
        chk("rd0_suppress", 32'(wb_valid), 32'd0);
        tick;
        dc.hit_ack = 1'b0;

        // hit rd 7 collides with return rd 3 -> skid
        issue(1'b1, 5'd7, 32'h700, 32'h0);
        dc.hit_ack = 1'b1; dc.load_done_stall = 1'b1; dc.regD_out = 5'd3; dc.load_data = 32'h33;
        #1;
        chk("coll_wbv", 32'(wb_valid), 32'd1);
        chk("coll_rd", 32'(wb_rd), 32'd3);
        chk("coll_data", wb_data, 32'h33);
        tick;
        dc.hit_ack = 1'b0; dc.load_done_stall = 1'b0; src1 = 5'd3; src2 = 5'd4;
        #1;
        chk("skid_wbv", 32'(wb_valid), 32'd1);
        chk("skid_rd", 32'(wb_rd), 32'd7);
        chk("skid_in_resp", 32'(req_ready), 32'd0);
        chk("skid_busy4", 32'(src_busy), 32'd1);
        src2 = 5'd0;
        #1;
        chk("skid_free3", 32'(src_busy), 32'd0);
        tick;
        chk("skid_drained", 32'(wb_valid), 32'd0);
        chk("skid_idle", 32'(req_ready), 32'd1);
        chk("final_hitcnt", hit_cnt, 32'd6);

        // reset mid-operation
        req_valid = 1'b1; req_lw = 1'b0; req_addr = 32'h800;
        tick;
        req_valid = 1'b0;
        #1;
        chk("midop_send", 32'(dc.send_pulse), 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_send", 32'(dc.send_pulse), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_addr", dc.addr_in, 32'd0);
        chk("midrst_miss", miss_cnt, 32'd0);
        rst = 1'b1;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
